pooling_max_window_reader: RTL and testbench
============================================

Name: pooling_max_window_reader

Overview:
- Read-side counterpart of the serial max-pooling cell.
- Walks a feature map held in the layer buffer and issues one read per window element over the buffer's synchronous read port.
- Folds each returned element into a running floating-point maximum and emits one pooled value per window on a valid/ready stream to the next layer.
- Non-overlapping POOL x POOL windows, stride POOL, row-major window order.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (global define), element width (IEEE-754 single).
- FM_WIDTH, 24, feature-map columns.
- FM_HEIGHT, 24, feature-map rows.
- POOL, 2, window edge and stride.
- ADDR_WIDTH, 10, buffer address width; must satisfy 2**ADDR_WIDTH >= FM_WIDTH*FM_HEIGHT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to pool the whole map.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_WIDTH  buffer read address.
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  pooled maximum.
- out_last  out  1  marks the final window of the map; qualified by out_valid.

Behaviour:
- Reset (asynchronous, any time, including mid-map):
  - State returns to IDLE.
  - busy, done, rd_en, out_valid and out_last go to 0; rd_addr, out_data and all counters go to 0.
  - The in-flight read is discarded.
- Output geometry:
  - Windows per row WX = FM_WIDTH/POOL and window rows WY = FM_HEIGHT/POOL, integer division; trailing rows/columns are dropped.
  - Total outputs = WX*WY.
- Address of element (ky,kx) in window (wy,wx) = (wy*POOL+ky)*FM_WIDTH + wx*POOL + kx. Elements are read row-major inside each window.
- State machine:
  - IDLE: on start=1 -> READ, window counters cleared. start is ignored in every other state.
  - READ: rd_en=1 for exactly K=POOL*POOL consecutive cycles, one address per cycle. After the K-th read -> DRAIN.
  - DRAIN: one cycle in which the last rd_data is folded in -> OUT.
  - OUT: out_valid=1; out_data and out_last stay stable until out_ready=1.
    - On handshake with windows remaining: advance window (wx, wrapping to next wy) -> READ.
    - On handshake of the final window -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Accumulation:
  - Element returned for read index 0 loads the max register unconditionally; there is no zero seed, so all-negative windows give a negative result.
  - Later elements replace the max only if strictly greater per the floating comparator; ties keep the held value.
- Timing per window: the first read is in the cycle READ is entered; out_valid rises K+1 cycles after that cycle. Window period is K+2 cycles when out_ready is held high.
- Backpressure: while in OUT with out_ready=0, no reads are issued and nothing changes.
- out_ready while out_valid=0 has no effect.
- out_last=1 only together with out_valid on window index WX*WY-1.

Decomposition:
- Shared pooling package holds:
  - state enum {IDLE, READ, DRAIN, OUT, DONE};
  - derived constants K, WX, WY;
  - address-arithmetic function.
- One sub-module: pooling_max_accum, holding the running-max register with load_first/enable and wrapping floating_comparator_sim. Reset behaviour: asynchronous active-low, max register cleared to 0.

Test Plan:
- Basic map: FM 4x4, POOL 2, buffer holds 1.0..16.0 row-major, out_ready=1. Required outputs in order 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0); out_last only on the 4th; done pulses once; each output 6 cycles apart.
- All-negative map: same FM with -1.0..-16.0. Required outputs -1.0 (0xBF800000), -3.0 (0xC0400000), -9.0 (0xC1100000), -11.0 (0xC1300000). Fails if the max is seeded with 0.
- Ties and max position:
  - Windows {5,5,5,5} -> output 5.0.
  - Window with the max at element 3 -> output is that element.
  - Window with the max at element 0 -> output is that element.
- Backpressure: out_ready=0 for 5 cycles on window 1. out_valid and out_data are held; rd_en stays 0 throughout; the sequence is otherwise identical to the basic map.
- start during busy: a second start pulse mid-map has no effect; exactly 4 outputs and a single done pulse.
- Reset mid-operation: assert rst_n=0 during READ of window 2. All outputs go to 0 immediately. After release, a fresh start produces the full basic-map sequence from window 0.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared pooling definitions: controller states, window geometry and
// buffer address arithmetic.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} pool_state_e;

    localparam int unsigned DEF_FM_WIDTH  = 24;
    localparam int unsigned DEF_FM_HEIGHT = 24;
    localparam int unsigned DEF_POOL      = 2;

    function automatic int unsigned pool_k(input int unsigned pool);
        return pool * pool;
    endfunction

    // Integer division: trailing rows/columns that do not fill a window are dropped.
    function automatic int unsigned pool_windows(input int unsigned fm, input int unsigned pool);
        return fm / pool;
    endfunction

    localparam int unsigned K  = pool_k(DEF_POOL);
    localparam int unsigned WX = pool_windows(DEF_FM_WIDTH, DEF_POOL);
    localparam int unsigned WY = pool_windows(DEF_FM_HEIGHT, DEF_POOL);

    function automatic int unsigned elem_addr(
        input int unsigned wy,
        input int unsigned wx,
        input int unsigned ky,
        input int unsigned kx,
        input int unsigned fm_width,
        input int unsigned pool
    );
        return (wy * pool + ky) * fm_width + wx * pool + kx;
    endfunction

endpackage

// File: rtl/floating_comparator_sim.sv
// Combinational IEEE-754 strict greater-than: a_gt_b = (a > b).
// +0 and -0 compare equal; any NaN operand yields 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module floating_comparator_sim #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int MW = (DATA_WIDTH == 64) ? 52 : (DATA_WIDTH == 16) ? 10 : 23;
    localparam int EW = DATA_WIDTH - 1 - MW;

    logic                  sa, sb, nan_a, nan_b, both_zero;
    logic [DATA_WIDTH-2:0] ma, mb;

    always_comb begin
        sa        = a[DATA_WIDTH-1];
        sb        = b[DATA_WIDTH-1];
        ma        = a[DATA_WIDTH-2:0];
        mb        = b[DATA_WIDTH-2:0];
        nan_a     = (&a[DATA_WIDTH-2 -: EW]) && (|a[MW-1:0]);
        nan_b     = (&b[DATA_WIDTH-2 -: EW]) && (|b[MW-1:0]);
        both_zero = (ma == '0) && (mb == '0);
        a_gt_b    = 1'b0;
        if (!nan_a && !nan_b && !both_zero) begin
            unique case ({sa, sb})
                2'b00:   a_gt_b = ma > mb;
                2'b01:   a_gt_b = 1'b1;
                2'b10:   a_gt_b = 1'b0;
                default: a_gt_b = ma < mb;
            endcase
        end
    end

endmodule

// File: rtl/pooling_max_accum.sv
// Running-maximum register: load_first loads unconditionally, enable folds in
// the new element only when it is strictly greater than the held value.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_max_accum #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_first,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] max_out
);

    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  din_gt;

    floating_comparator_sim #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a      (din),
        .b      (max_q),
        .a_gt_b (din_gt)
    );

    always_comb begin
        max_d = max_q;
        if (load_first) begin
            max_d = din;
        end else if (enable && din_gt) begin
            max_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_q <= '0;
        else        max_q <= max_d;
    end

    assign max_out = max_q;

endmodule

// File: rtl/pooling_max_window_reader.sv
// Max-pooling reader: walks POOL x POOL windows of a feature map over a
// synchronous read port and streams one pooled maximum per window.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_max_window_reader
    import pooling_pkg::*;
#(
    parameter int          DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned FM_WIDTH   = 24,
    parameter int unsigned FM_HEIGHT  = 24,
    parameter int unsigned POOL       = 2,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned WX_L = pool_windows(FM_WIDTH, POOL);
    localparam int unsigned WY_L = pool_windows(FM_HEIGHT, POOL);
    localparam int          KW   = $clog2(POOL) + 1;

    pool_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wx_q, wx_d, wy_q, wy_d;
    logic [KW-1:0]         kx_q, kx_d, ky_q, ky_d;
    logic                  rd_valid_q, rd_valid_d, first_q, first_d;
    logic                  last_win;

    assign last_win = (wx_q == ADDR_WIDTH'(WX_L - 1)) && (wy_q == ADDR_WIDTH'(WY_L - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wx_q       <= '0;
            wy_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            rd_valid_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            rd_valid_q <= rd_valid_d;
            first_q    <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    wx_d    = '0;
                    wy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                end
            end
            READ: begin
                if (kx_q == KW'(POOL - 1)) begin
                    kx_d = '0;
                    if (ky_q == KW'(POOL - 1)) begin
                        ky_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        ky_d = ky_q + 1'b1;
                    end
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    if (last_win) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        if (wx_q == ADDR_WIDTH'(WX_L - 1)) begin
                            wx_d = '0;
                            wy_d = wy_q + 1'b1;
                        end else begin
                            wx_d = wx_q + 1'b1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data lags rd_en by one cycle; the pipeline flags tag it for the accumulator.
    always_comb begin
        busy       = (state_q == READ) || (state_q == DRAIN) || (state_q == OUT);
        done       = (state_q == DONE);
        rd_en      = (state_q == READ);
        out_valid  = (state_q == OUT);
        out_last   = (state_q == OUT) && last_win;
        rd_addr    = ADDR_WIDTH'(elem_addr(32'(wy_q), 32'(wx_q), 32'(ky_q), 32'(kx_q),
                                           FM_WIDTH, POOL));
        rd_valid_d = rd_en;
        first_d    = rd_en && (kx_q == '0) && (ky_q == '0);
    end

    pooling_max_accum #(.DATA_WIDTH(DATA_WIDTH)) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_first (first_q),
        .enable     (rd_valid_q),
        .din        (rd_data),
        .max_out    (out_data)
    );

endmodule

// File: tb/tb_pooling_max_window_reader.sv
// Directed bench for pooling_max_window_reader on a 4x4 map with 2x2 windows.
module tb_pooling_max_window_reader;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    pooling_max_window_reader #(
        .DATA_WIDTH (DW),
        .FM_WIDTH   (4),
        .FM_HEIGHT  (4),
        .POOL       (2),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Synchronous layer buffer: data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fl(input int n);
        case (n)
            1:  return 32'h3F800000;
            2:  return 32'h40000000;
            3:  return 32'h40400000;
            4:  return 32'h40800000;
            5:  return 32'h40A00000;
            6:  return 32'h40C00000;
            7:  return 32'h40E00000;
            8:  return 32'h41000000;
            9:  return 32'h41100000;
            10: return 32'h41200000;
            11: return 32'h41300000;
            12: return 32'h41400000;
            13: return 32'h41500000;
            14: return 32'h41600000;
            15: return 32'h41700000;
            16: return 32'h41800000;
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic load_seq(input bit neg);
        for (int i = 0; i < 16; i++) mem[i] = fl(i + 1) | (neg ? 32'h80000000 : 32'h0);
    endtask

    task automatic load_ties();
        int v [16] = '{5, 5, 1, 2,
                       5, 5, 3, 9,
                       7, 1, 2, 4,
                       2, 3, 4, 1};
        for (int i = 0; i < 16; i++) mem[i] = fl(v[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_map(input string tag,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input bit bp, input bit restart);
        logic [31:0] exp_v [4];
        logic [31:0] gd [8];
        logic        gl [8];
        int          gc [8];
        int          n_out    = 0;
        int          done_cnt = 0;
        bit          bp_done  = 1'b0;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 60; c++) begin
            if (restart) begin
                start = (c == 8);
                if (c == 8) check({tag, "_busy_at_restart"}, busy, 1);
            end
            if (bp && !bp_done && out_valid && n_out == 1) begin
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("%s_bp_valid%0d", tag, i), out_valid, 1);
                    check($sformatf("%s_bp_data%0d", tag, i), out_data, exp_v[1]);
                    check($sformatf("%s_bp_rden%0d", tag, i), rd_en, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                bp_done   = 1'b1;
            end
            if (out_valid && out_ready && n_out < 8) begin
                gd[n_out] = out_data;
                gl[n_out] = out_last;
                gc[n_out] = cyc;
                n_out++;
            end
            if (done) begin
                done_cnt++;
                check({tag, "_busy_at_done"}, busy, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_n_out"}, n_out, 4);
        check({tag, "_done_cnt"}, done_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", tag, i), gd[i], exp_v[i]);
            check($sformatf("%s_last%0d", tag, i), gl[i], (i == 3) ? 1 : 0);
        end
        for (int i = 1; i < 4; i++)
            check($sformatf("%s_gap%0d", tag, i), gc[i] - gc[i-1], (bp && i == 1) ? 11 : 6);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        load_seq(1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_map("basic", fl(6), fl(8), fl(14), fl(16), 1'b0, 1'b0);

        load_seq(1'b1);
        run_map("neg", 32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000, 1'b0, 1'b0);

        load_ties();
        run_map("ties", fl(5), fl(9), fl(7), fl(4), 1'b0, 1'b0);

        load_seq(1'b0);
        run_map("bp", fl(6), fl(8), fl(14), fl(16), 1'b1, 1'b0);

        run_map("restart", fl(6), fl(8), fl(14), fl(16), 1'b0, 1'b1);

        // Reset in the first READ cycle of window 2 (address 8).
        found = 1'b0;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            if (rd_en && rd_addr == 4'd8) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midreset_reached_w2", found, 1);
        check("midreset_pre_data", out_data, fl(8));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_idle_busy", busy, 0);
        check("midreset_idle_rden", rd_en, 0);
        run_map("after_reset", fl(6), fl(8), fl(14), fl(16), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
